// File: rtl/flipflop_cmd_driver_pkg.sv
// Shared types and constants for the b1/b2 flip-flop command driver.
// Command encodings are ordered {b2, b1}; b2 = 1 means "load b1".
package flipflop_cmd_driver_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic b2;
    logic b1;
  } cmd_t;

  localparam cmd_t CMD_HOLD   = cmd_t'(2'b00);
  localparam cmd_t CMD_TOGGLE = cmd_t'(2'b01);
  localparam cmd_t CMD_LOAD_0 = cmd_t'(2'b10);
  localparam cmd_t CMD_LOAD_1 = cmd_t'(2'b11);

  // A forced load wins; otherwise hold if the flop already sits at t, else toggle.
  function automatic cmd_t select_cmd(input logic force_load, input logic t, input logic shadow);
    cmd_t cmd;
    if (force_load) begin
      cmd = t ? CMD_LOAD_1 : CMD_LOAD_0;
    end else if (t == shadow) begin
      cmd = CMD_HOLD;
    end else begin
      cmd = CMD_TOGGLE;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/flipflop_cmd_driver_if.sv
// Word-input handshake plus command/status outputs of the flip-flop command driver.
// The producer of target words uses master; the driver itself uses slave.
interface flipflop_cmd_driver_if #(
  parameter int unsigned WIDTH = 8
);
  import flipflop_cmd_driver_pkg::*;

  logic [WIDTH-1:0] word_in;
  logic             word_valid;
  logic             word_ready;
  logic             b1;
  logic             b2;
  logic             cmd_valid;
  logic             busy;
  logic             done;
  logic             shadow_q;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] toggle_cnt;
  logic [CNT_W-1:0] load_cnt;

  modport master (
    output word_in, word_valid,
    input  word_ready, b1, b2, cmd_valid, busy, done, shadow_q,
    input  hold_cnt, toggle_cnt, load_cnt
  );

  modport slave (
    input  word_in, word_valid,
    output word_ready, b1, b2, cmd_valid, busy, done, shadow_q,
    output hold_cnt, toggle_cnt, load_cnt
  );

endinterface

// File: rtl/flipflop_cmd_counter.sv
// Saturating up-counter with increment enable; sticks at all-ones instead of wrapping.
module flipflop_cmd_counter
  import flipflop_cmd_driver_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/flipflop_cmd_driver.sv
// Serialises target words MSB-first into per-cycle {b2,b1} flop commands,
// tracking a shadow of the flop's q2 and forcing periodic loads to resync it.
module flipflop_cmd_driver
  import flipflop_cmd_driver_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned REFRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  flipflop_cmd_driver_if.slave bus
);

  localparam int unsigned IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned SL_W       = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam bit          REFRESH_EN = (REFRESH != 0);
  localparam logic [SL_W-1:0] SL_MAX = REFRESH_EN ? SL_W'(REFRESH - 1) : '0;

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic [IDX_W-1:0] idx_m1;
  logic             sync_pending_q;
  logic             sync_pending_d;
  logic [SL_W-1:0]  since_load_q;
  logic [SL_W-1:0]  since_load_d;

  logic b1_q, b1_d;
  logic b2_q, b2_d;
  logic cmd_valid_q, cmd_valid_d;
  logic done_q, done_d;
  logic busy_q, busy_d;
  logic word_ready_q, word_ready_d;
  logic shadow_q, shadow_d;

  logic accept_c;
  logic step_c;
  logic emit_c;
  logic t_c;
  logic force_load_c;
  cmd_t cmd_c;

  logic hold_inc;
  logic toggle_inc;
  logic load_inc;

  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] toggle_cnt;
  logic [CNT_W-1:0] load_cnt;

  // The MSB command is produced on the acceptance edge itself, straight from word_in.
  assign accept_c     = (state_q == ST_IDLE) && bus.word_valid;
  assign step_c       = (state_q == ST_SHIFT) && (idx_q != '0);
  assign emit_c       = accept_c || step_c;
  assign idx_m1       = idx_q - IDX_W'(1);
  assign t_c          = accept_c ? bus.word_in[WIDTH-1] : word_q[idx_m1];
  assign force_load_c = sync_pending_q || (REFRESH_EN && (since_load_q == SL_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.word_valid) state_d = ST_SHIFT;
      ST_SHIFT: if (idx_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    word_d         = word_q;
    idx_d          = idx_q;
    sync_pending_d = sync_pending_q;
    since_load_d   = since_load_q;
    shadow_d       = shadow_q;
    b1_d           = 1'b0;
    b2_d           = 1'b0;
    cmd_valid_d    = 1'b0;
    done_d         = (state_q == ST_SHIFT) && (idx_q == '0);
    busy_d         = (state_d != ST_IDLE);
    word_ready_d   = (state_d == ST_IDLE);
    hold_inc       = 1'b0;
    toggle_inc     = 1'b0;
    load_inc       = 1'b0;
    cmd_c          = CMD_HOLD;

    if (accept_c) begin
      word_d = bus.word_in;
      idx_d  = IDX_W'(WIDTH - 1);
    end else if (step_c) begin
      idx_d = idx_m1;
    end

    if (emit_c) begin
      cmd_c       = select_cmd(force_load_c, t_c, shadow_q);
      b1_d        = cmd_c.b1;
      b2_d        = cmd_c.b2;
      cmd_valid_d = 1'b1;
      shadow_d    = t_c;
      if (cmd_c.b2) begin
        load_inc       = 1'b1;
        sync_pending_d = 1'b0;
        since_load_d   = '0;
      end else begin
        if (cmd_c.b1) begin
          toggle_inc = 1'b1;
        end else begin
          hold_inc = 1'b1;
        end
        // Never exceeds SL_MAX: reaching it forces the next command to a load.
        if (REFRESH_EN) begin
          since_load_d = since_load_q + SL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q         <= '0;
      idx_q          <= '0;
      sync_pending_q <= 1'b1;
      since_load_q   <= '0;
      shadow_q       <= 1'b0;
      b1_q           <= 1'b0;
      b2_q           <= 1'b0;
      cmd_valid_q    <= 1'b0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
      word_ready_q   <= 1'b1;
    end else begin
      word_q         <= word_d;
      idx_q          <= idx_d;
      sync_pending_q <= sync_pending_d;
      since_load_q   <= since_load_d;
      shadow_q       <= shadow_d;
      b1_q           <= b1_d;
      b2_q           <= b2_d;
      cmd_valid_q    <= cmd_valid_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
      word_ready_q   <= word_ready_d;
    end
  end

  flipflop_cmd_counter #(.W(CNT_W)) u_hold_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (hold_inc),
    .cnt_o (hold_cnt)
  );

  flipflop_cmd_counter #(.W(CNT_W)) u_toggle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (toggle_inc),
    .cnt_o (toggle_cnt)
  );

  flipflop_cmd_counter #(.W(CNT_W)) u_load_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (load_inc),
    .cnt_o (load_cnt)
  );

  assign bus.word_ready = word_ready_q;
  assign bus.b1         = b1_q;
  assign bus.b2         = b2_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.shadow_q   = shadow_q;
  assign bus.hold_cnt   = hold_cnt;
  assign bus.toggle_cnt = toggle_cnt;
  assign bus.load_cnt   = load_cnt;

endmodule

// File: doc/flipflop_cmd_driver.md
# flipflop_cmd_driver

Command-side driver for the b1/b2 dual-input flip-flop. It accepts target bit-words over a valid/ready handshake and serialises each word MSB-first into per-cycle (b1, b2) command pairs that move the flop's q2 to each target bit. It keeps a shadow copy of the flop state and picks hold, toggle or load for each bit. It forces periodic load commands so that the shadow and the real flop resynchronise. It sits directly upstream of the flip-flop and shares its clock.

## Interface
- WIDTH, 8: bits per target word; ≥1.
- REFRESH, 4: every REFRESH-th command is forced to a load; 0 disables forced refresh.
- clk  in  1  posedge clock, shared with the flip-flop
- rst_n  in  1  asynchronous, active-low reset
- word_in  in  WIDTH  target word, MSB sent first
- word_valid  in  1  word_in valid
- word_ready  out  1  driver can accept a word
- b1  out  1  flop command bit b1
- b2  out  1  flop command bit b2 (1 = load b1)
- cmd_valid  out  1  b1/b2 carry a real command this cycle
- busy  out  1  word in flight (SHIFT or DONE)
- done  out  1  one-cycle pulse after the last bit of a word
- shadow_q  out  1  modelled flop q2 after the current command
- hold_cnt, toggle_cnt, load_cnt  out  16 each  saturating command counters

## Operation
- Reset values (asynchronous):
  - All outputs are 0, except word_ready = 1.
  - State is IDLE, the internal sync_pending flag = 1 and since_load = 0.
- FSM states are IDLE, SHIFT and DONE.
- **IDLE**
  - word_ready = 1.
  - When word_valid and word_ready are both 1 at a clock edge: latch word_in, set idx = WIDTH-1, go to SHIFT.
- **SHIFT**
  - word_ready = 0 and cmd_valid = 1.
  - Each cycle emits one command for t = word[idx], then decrements idx.
  - When idx = 0 has been emitted, go to DONE.
- **DONE**
  - One cycle only: done = 1, cmd_valid = 0, then go to IDLE.
- Command selection, applied to each bit in priority order:
  1. If sync_pending = 1, or (REFRESH ≠ 0 and since_load = REFRESH-1): load, i.e. b2 = 1, b1 = t. Clear sync_pending, set since_load = 0, increment load_cnt.
  2. Else if t = shadow_q: hold, i.e. b2 = 0, b1 = 0. Increment hold_cnt and since_load.
  3. Else: toggle, i.e. b2 = 0, b1 = 1. Increment toggle_cnt and since_load.
- shadow_q is updated to t with every command.
- Whenever cmd_valid = 0, b1 = b2 = 0. This is a hold, which is safe for the flop.
- since_load and sync_pending persist across words. The refresh cadence is counted over the command stream, not per word.
- Counters saturate at 16'hFFFF and never wrap.
- word_valid while busy is ignored. The input word is not re-sampled mid-word.

## Timing
- Acceptance edge E0: b1/b2 for the MSB are registered at E0 and are valid during the cycle after E0. The flop consumes them at E1.
- Bit k (MSB = 0) is presented in cycle E0+k, with no gaps.
- done is high in cycle E0+WIDTH.
- word_ready returns high in cycle E0+WIDTH+1.
- Sustained throughput is one word per WIDTH+2 cycles.
- shadow_q equals the flop's q2 one cycle after each command edge, provided the flop and the driver were reset together.
- Reset mid-operation:
  - The word is aborted immediately.
  - b1 = b2 = 0 and counters = 0.
  - sync_pending = 1, so the next word starts with a load.
- Simultaneous events:
  - done and a new word_valid in the same cycle: the word is not accepted; it is accepted in the next IDLE cycle.
  - A forced load always wins over hold/toggle, even when t already equals shadow_q.

## Structure
- The shared package holds:
  - the state enum (IDLE/SHIFT/DONE);
  - the command encodings CMD_HOLD = 2'b00, CMD_TOGGLE = 2'b01, CMD_LOAD_0 = 2'b10, CMD_LOAD_1 = 2'b11, ordered as {b2, b1};
  - the counter width constant CNT_W = 16.
- One sub-module, flipflop_cmd_counter: a saturating CNT_W-bit counter with an increment enable. It is instantiated three times.

## Test plan
- Reset, then send word 8'h00 with REFRESH=4:
  - commands are L0, H, H, H, L0, H, H, H;
  - load_cnt = 2, hold_cnt = 6, toggle_cnt = 0;
  - done pulses in cycle E0+8.
- Continue with word 8'hAA:
  - since_load is 3, so the first bit is L1;
  - commands are L1, T, T, T, L1, T, T, T;
  - final counters are load_cnt = 4, toggle_cnt = 6, and shadow_q = 0.
- REFRESH=0, reset, send word 8'hF0:
  - commands are L1, H, H, H, T, H, H, H;
  - load_cnt = 1, hold_cnt = 6, toggle_cnt = 1.
- Hold word_valid high continuously with two words queued:
  - the second word is accepted exactly WIDTH+2 cycles after the first;
  - word_ready = 0 throughout SHIFT and DONE.
- Assert rst_n low at bit 3 of 8'h5A:
  - outputs go to 0 immediately;
  - the next word 8'h01 begins with L0.
- Integration with the flip-flop, 20 random words:
  - the flop's q2 matches shadow_q one cycle after every command;
  - the serialised q2 sequence equals the sent words, MSB first.
